fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter and credit controller placed in front of the synchronous FIFO. It shares the FIFO's single write port between `NUM_REQ` requesters and grants at most one requester per cycle. It registers the winning data into the FIFO write port and tracks FIFO occupancy itself, so a grant is never issued into a write that would overflow.

---
 rtl/fifo_wr_arb_pkg.sv | 19 +
 rtl/fifo_wr_arb_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arbiter shared types, default parameters and helpers.
// Imported by the round-robin picker and the arbiter top level.
package fifo_wr_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    // Wide enough for up to 256 requesters.
    localparam int REQ_IDX_W = 8;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: scans upward from last_gnt+1
// with wrap-around and returns the one-hot winner and its index.
module fifo_wr_arb_rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last_gnt,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output req_idx_t           gnt_idx
);

    logic found;
    int   k;

    // First requester after last_gnt wins; nothing wins when disabled.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(last_gnt) + i) % NUM_REQ;
            if (enable && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = req_idx_t'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and credit controller for a sync FIFO.
// Optional grant statistics counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_data,
    output logic [NUM_REQ-1:0]                   gnt,
    input  logic                                 fifo_rd_en,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr_en,
    output logic [DATA_WIDTH-1:0]                fifo_wr_data,
    output logic [occ_width(FIFO_DEPTH)-1:0]     occupancy,
    output logic                                 ctrl_full,
    output logic                                 ctrl_empty,
    output logic                                 err_underflow,
    output logic [NUM_REQ*CNT_WIDTH-1:0]         grant_cnt
);

    localparam int OCC_W = occ_width(FIFO_DEPTH);

    req_idx_t         last_gnt;
    req_idx_t         pick_idx;
    logic             can_grant;
    logic             pick_en;
    logic             any_gnt;
    logic [OCC_W-1:0] occ_nxt;
    logic             under_hit;

    // Conservative credit: an in-flight write counts, a same-cycle pop does not.
    always_comb begin
        can_grant = !fifo_full &&
                    ((int'(occupancy) + int'(fifo_wr_en)) < FIFO_DEPTH);
        pick_en   = rst && can_grant;
    end

    fifo_wr_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .enable   (pick_en),
        .gnt      (gnt),
        .gnt_idx  (pick_idx)
    );

    assign any_gnt    = |gnt;
    assign ctrl_full  = (occupancy == OCC_W'(FIFO_DEPTH));
    assign ctrl_empty = (occupancy == '0);

    // Next fill level; a pop against an empty count flags underflow.
    always_comb begin
        occ_nxt   = occupancy;
        under_hit = 1'b0;
        unique case ({fifo_wr_en, fifo_rd_en})
            2'b10: occ_nxt = occupancy + OCC_W'(1);
            2'b01: begin
                if (ctrl_empty) under_hit = 1'b1;
                else            occ_nxt   = occupancy - OCC_W'(1);
            end
            2'b11: under_hit = ctrl_empty;
            default: ;
        endcase
    end

    // Register the winner into the FIFO write port and track occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt      <= req_idx_t'(NUM_REQ - 1);
            fifo_wr_en    <= 1'b0;
            fifo_wr_data  <= '0;
            occupancy     <= '0;
            err_underflow <= 1'b0;
        end else begin
            fifo_wr_en <= any_gnt;
            if (any_gnt) begin
                last_gnt     <= pick_idx;
                fifo_wr_data <= req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            occupancy <= occ_nxt;
            if (under_hit) err_underflow <= 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters.
// Inputs change after negedge; outputs are sampled 1ns later.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             fifo_rd_en;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_wr_data;
    logic [3:0]       occupancy;
    logic             ctrl_full;
    logic             ctrl_empty;
    logic             err_underflow;
    logic [NR*CW-1:0] grant_cnt;

    int n_run;
    int n_fail;
    int ngr;

    fifo_wr_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .occupancy     (occupancy),
        .ctrl_full     (ctrl_full),
        .ctrl_empty    (ctrl_empty),
        .err_underflow (err_underflow),
        .grant_cnt     (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Two reset edges with requests pending; returns in the first
    // cycle with rst released and req cleared.
    task automatic reset_dut();
        nxt();
        rst = 1'b0; req = '1; fifo_rd_en = 1'b0; fifo_full = 1'b0;
        #1 check("rst_gnt_forced", 64'(gnt), 64'd0);
        nxt();
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        check("rst_wr_data", 64'(fifo_wr_data), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_empty", 64'(ctrl_empty), 64'd1);
        check("rst_full", 64'(ctrl_full), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        check("rst_cnt", 64'(grant_cnt), 64'd0);
        nxt();
        rst = 1'b1; req = '0;
    endtask

    logic [7:0] exp_d [4];
    logic [63:0] exp_c0;
    logic [63:0] exp_c2;

    initial begin
        n_run = 0; n_fail = 0;
        rst = 1'b0; req = '0; fifo_rd_en = 1'b0; fifo_full = 1'b0;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        exp_d[0] = 8'h10; exp_d[1] = 8'h21;
        exp_d[2] = 8'h32; exp_d[3] = 8'h43;

        // Idle after reset
        reset_dut();
        #1;
        check("idle_empty", 64'(ctrl_empty), 64'd1);
        check("idle_occ", 64'(occupancy), 64'd0);
        check("idle_gnt", 64'(gnt), 64'd0);
        check("idle_wr_en", 64'(fifo_wr_en), 64'd0);

        // All four request: grants 0,1,2,3, data one cycle later
        nxt(); req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_gnt", 64'(gnt), 64'(1 << i));
            if (i > 0) begin
                check("rr_wr_en", 64'(fifo_wr_en), 64'd1);
                check("rr_wr_data", 64'(fifo_wr_data), 64'(exp_d[i-1]));
            end
            nxt();
        end
        req = '0;
        #1;
        check("rr_gnt_off", 64'(gnt), 64'd0);
        check("rr_wr_data3", 64'(fifo_wr_data), 64'h43);
        nxt(); #1;
        check("rr_occ", 64'(occupancy), 64'd4);
        check("rr_wr_en_off", 64'(fifo_wr_en), 64'd0);
        check("rr_data_hold", 64'(fifo_wr_data), 64'h43);

        // Single requester fills the FIFO: 8 grants then none
        reset_dut();
        req = 4'b0001; ngr = 0;
        for (int i = 0; i < 10; i++) begin
            #1 if (gnt == 4'b0001) ngr++;
            nxt();
        end
        #1;
        check("fill_grants", 64'(ngr), 64'd8);
        check("fill_gnt_off", 64'(gnt), 64'd0);
        check("fill_occ", 64'(occupancy), 64'd8);
        check("fill_full", 64'(ctrl_full), 64'd1);
        fifo_rd_en = 1'b1;
        #1 check("pop_gnt_cons", 64'(gnt), 64'd0);
        nxt(); fifo_rd_en = 1'b0; ngr = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (gnt == 4'b0001) ngr++;
            nxt();
        end
        #1;
        check("pop_grants", 64'(ngr), 64'd1);
        check("pop_occ", 64'(occupancy), 64'd8);

        // fifo_full interlock, then sparse round-robin wrap
        reset_dut();
        fifo_full = 1'b1; req = 4'b0001;
        #1 check("ffull_gnt", 64'(gnt), 64'd0);
        nxt(); #1 check("ffull_wr_en", 64'(fifo_wr_en), 64'd0);
        fifo_full = 1'b0;
        #1 check("ffull_rel_gnt", 64'(gnt), 64'b0001);
        nxt(); req = 4'b1010;
        #1 check("wrap_gnt1", 64'(gnt), 64'b0010);
        nxt(); req = 4'b1001;
        #1 check("wrap_gnt3", 64'(gnt), 64'b1000);
        nxt();
        #1 check("wrap_gnt0", 64'(gnt), 64'b0001);
        nxt(); req = '0;

        // Underflow is sticky until reset
        reset_dut();
        fifo_rd_en = 1'b1;
        #1 check("uf_pre", 64'(err_underflow), 64'd0);
        nxt(); fifo_rd_en = 1'b0;
        #1;
        check("uf_set", 64'(err_underflow), 64'd1);
        check("uf_occ", 64'(occupancy), 64'd0);
        nxt(); #1 check("uf_sticky", 64'(err_underflow), 64'd1);
        reset_dut();
        #1 check("uf_clr", 64'(err_underflow), 64'd0);

        // Write and pop together at occupancy 3
        req = 4'b0001;
        nxt(); nxt(); nxt(); req = '0;
        nxt(); nxt();
        #1 check("wp_occ3", 64'(occupancy), 64'd3);
        req = 4'b0001;
        nxt(); req = '0; fifo_rd_en = 1'b1;
        #1 check("wp_wr_en", 64'(fifo_wr_en), 64'd1);
        nxt(); fifo_rd_en = 1'b0;
        #1 check("wp_occ_a", 64'(occupancy), 64'd3);
        nxt(); #1 check("wp_occ_b", 64'(occupancy), 64'd3);

        // Statistics: 0101 alternates 0,2,0,2,0,2
        reset_dut();
        req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            #1 check("st_gnt", 64'(gnt), (i % 2 == 0) ? 64'b0001 : 64'b0100);
            nxt();
        end
        req = '0;
        nxt();
`ifdef FIFO_WR_ARB_STATS_EN
        exp_c0 = 64'd3; exp_c2 = 64'd3;
`else
        exp_c0 = 64'd0; exp_c2 = 64'd0;
`endif
        #1;
        check("st_cnt0", 64'(grant_cnt[0*CW +: CW]), exp_c0);
        check("st_cnt1", 64'(grant_cnt[1*CW +: CW]), 64'd0);
        check("st_cnt2", 64'(grant_cnt[2*CW +: CW]), exp_c2);
        check("st_cnt3", 64'(grant_cnt[3*CW +: CW]), 64'd0);

        // Reset mid-burst drops the pending write and clears counters
        req = 4'b0001;
        #1 check("mb_gnt", 64'(gnt), 64'b0001);
        reset_dut();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
